// File: rtl/dpram_reader_m.sv
// dpram_reader_m: streaming read engine for one port of a true dual-port RAM.
// Accepts a (start address, length-1) command, issues sequential reads on the RAM
// port and presents the returned words as a valid/ready stream marked with last.
// The RAM's one-cycle read latency is absorbed by a 2-entry {data, last} buffer
// plus an in-flight tracker, so back-pressure never loses or overflows data.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_addr, cmd_len     start word address, word count minus one
//   rd_addr, rd_q         RAM read address (registered) and read data
//   out_valid/out_ready   output stream handshake
//   out_data, out_last    output word and final-word marker
//   busy, done            command in progress, one-cycle completion pulse
//   abort                 only when DPRAM_READER_ABORT_EN is defined
//
// Optional feature macro: DPRAM_READER_ABORT_EN adds the abort input.
module dpram_reader_m #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
`ifdef DPRAM_READER_ABORT_EN
  input  logic          abort,
`endif
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic          done_q, done_d;
  logic [1:0]    occ_q, occ_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] buf_data_q [2];
  logic          buf_last_q [2];

  logic          accept, pop, issue, abort_act;
  logic [2:0]    fill;

`ifdef DPRAM_READER_ABORT_EN
  assign abort_act = abort && (state_q != StIdle);
`else
  assign abort_act = 1'b0;
`endif

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rd_addr   = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_last  = out_valid && buf_last_q[rd_ptr_q];

  assign accept = cmd_valid && cmd_ready;
  assign pop    = out_valid && out_ready;
  // Buffer occupancy once the current in-flight word lands and this cycle's pop
  // leaves; a new read is only safe if its word will still find a free slot.
  assign fill   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue  = (state_q == StRead) && !abort_act && (fill < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    infl_d      = issue;
    infl_last_d = issue && (cnt_q == '0);
    done_d      = 1'b0;
    occ_d       = occ_q + {1'b0, infl_q} - {1'b0, pop};
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRead;
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
        end
      end
      StRead: begin
        if (abort_act) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (issue) begin
          addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
          cnt_d  = cnt_q - {{(AW-1){1'b0}}, 1'b1};
          if (cnt_q == '0) state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort_act) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_act) occ_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      occ_q       <= occ_d;
      if (abort_act) begin
        // Flush; a word arriving from the RAM this edge is simply not captured.
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (infl_q) begin
          buf_data_q[wr_ptr_q] <= rd_q;
          buf_last_q[wr_ptr_q] <= infl_last_q;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_dpram_reader_m.sv
// Self-checking bench for dpram_reader_m: a behavioural RAM feeds the DUT and the
// expected stream is ram[(cmd_addr + k) mod 256] for k = 0..cmd_len.
module tb_dpram_reader_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_addr, cmd_len;
  logic [7:0] rd_addr, rd_q;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last, busy, done;
`ifdef DPRAM_READER_ABORT_EN
  logic       abort;
`endif

  logic [7:0] ram [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rd_q <= ram[rd_addr];

  dpram_reader_m #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
`ifdef DPRAM_READER_ABORT_EN
    .abort     (abort),
`endif
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
  endtask

  // Runs one command and checks its whole stream. With chain set, the caller has
  // already raised cmd_valid in the current (negedge) cycle. With hold set,
  // cmd_valid stays high carrying the next command (na, nl) throughout.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] l, input int pct,
                         input bit chain, input bit hold, input logic [7:0] na,
                         input logic [7:0] nl);
    int         n = int'(l) + 1;
    int         got = 0;
    int         cyc = 0;
    int         first_v = -1;
    int         last_cyc = -1;
    bit         seen_done = 0;
    bit         stall = 0;
    logic [7:0] held = '0;
    logic [7:0] ea;
    if (!chain) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    check("accept_ready", 32'(cmd_ready), 32'd1);
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("rd_addr_first", 32'(rd_addr), 32'(a));
        check("busy_first", 32'(busy), 32'd1);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        if (hold) begin
          cmd_addr = na;
          cmd_len  = nl;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done) begin
        seen_done = 1;
        check("done_after_last", 32'(cyc), 32'(last_cyc + 1));
        check("ready_at_done", 32'(cmd_ready), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        if (pct == 100) check("done_latency", 32'(cyc), 32'(n + 3));
      end else begin
        if (out_valid && first_v < 0) first_v = cyc;
        if (stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_stable", 32'(out_data), 32'(held));
        end
        out_ready = ($urandom_range(99) < pct);
        if (out_valid && out_ready) begin
          ea = a + 8'(got);
          if (got < n) begin
            check("data", 32'(out_data), 32'(ram[ea]));
            check("last", 32'(out_last), 32'(got == n - 1));
          end
          got++;
          if (got == n) last_cyc = cyc;
        end
        stall = out_valid && !out_ready;
        held  = out_data;
      end
    end
    check("no_timeout", 32'(seen_done), 32'd1);
    check("word_count", 32'(got), 32'(n));
    check("first_valid", 32'(first_v), 32'd3);
    if (!hold) begin
      @(negedge clk);
      check("done_once", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int got;
    int cyc;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
`ifdef DPRAM_READER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd(8'h10, 8'd3, 100, 0, 0, 8'h00, 8'h00);
    run_cmd(8'hFE, 8'd3, 100, 0, 0, 8'h00, 8'h00);
    run_cmd(8'h33, 8'd0, 100, 0, 0, 8'h00, 8'h00);
    run_cmd(8'h00, 8'hFF, 50, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);

    // Back-to-back: cmd_valid never drops between the two commands.
    run_cmd(8'hA0, 8'd5, 100, 0, 1, 8'h20, 8'd9);
    run_cmd(8'h20, 8'd9, 70, 1, 0, 8'h00, 8'h00);

    for (int k = 0; k < 6; k++)
      run_cmd(8'($urandom), 8'($urandom_range(40)), 20 + 16 * k, 0, 0, 8'h00, 8'h00);

    // Reset in the middle of an 8-word command after two words have moved.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 8'h40;
    cmd_len   = 8'd7;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 50) begin
      if (out_valid && out_ready) got++;
      if (got < 2) @(negedge clk);
      cyc++;
    end
    check("rst_wait", 32'(got), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(8'h80, 8'd5, 100, 0, 0, 8'h00, 8'h00);

`ifdef DPRAM_READER_ABORT_EN
    // Abort a 16-word command after three words with the consumer stalled.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 8'h60;
    cmd_len   = 8'd15;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 50) begin
      if (out_valid && out_ready) got++;
      if (got == 3) out_ready = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("abort_wait", 32'(got), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_last", 32'(out_last), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet_valid", 32'(out_valid), 32'd0);
      check("abort_quiet_done", 32'(done), 32'd0);
    end
    run_cmd(8'hC8, 8'd4, 100, 0, 0, 8'h00, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
